uart_rx_fifo: RTL
=================

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameter NB_DATA, default 8: byte width of stored entries.
REQ-002 Parameter NB_ADDR, default 4: pointer width; depth DEPTH = 2^NB_ADDR (16 by default).
REQ-003 i_clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 i_reset  input  1  asynchronous, active-low reset; low clears all state immediately.
REQ-005 i_wr  input  1  write strobe; connects to the receiver's o_rx_done_tick (1-cycle pulse).
REQ-006 i_wr_data  input  NB_DATA  byte to store; connects to the receiver's o_rx_data.
REQ-007 i_rd  input  1  pop strobe from the command interface.
REQ-008 i_ovf_clr  input  1  clears the sticky overflow flag.
REQ-009 o_rd_data  output  NB_DATA  head entry (first-word-fall-through); valid while o_empty=0.
REQ-010 o_empty  output  1  FIFO holds zero entries.
REQ-011 o_full  output  1  FIFO holds DEPTH entries.
REQ-012 o_count  output  NB_ADDR+1  current occupancy, 0..DEPTH.
REQ-013 o_overflow  output  1  sticky flag: a byte was dropped.

Function
REQ-014 The block shall store bytes in a DEPTH x NB_DATA register array addressed by write and read pointers of NB_ADDR bits.
REQ-015 A write with o_full=0 shall store i_wr_data at the write pointer and advance it by 1 on the same edge.
REQ-016 A read with o_empty=0 shall advance the read pointer by 1; o_rd_data shall show the next entry on the following cycle.
REQ-017 Both pointers shall wrap from DEPTH-1 to 0 without any extra cycle.
REQ-018 Write-to-visible latency: after the edge accepting a write into an empty FIFO, o_empty shall be 0 and o_rd_data shall equal the written byte.
REQ-019 A write while full with i_rd=0 shall be dropped; memory, pointers and o_count shall be unchanged.
REQ-020 A read while empty shall be ignored; pointers and o_count shall be unchanged.
REQ-021 Simultaneous i_wr and i_rd while full: both shall execute, o_count stays DEPTH, and o_full stays 1.
REQ-022 Simultaneous i_wr and i_rd while empty: the write shall execute, the read shall be ignored, and o_count becomes 1.
REQ-023 Simultaneous i_wr and i_rd with 0<o_count<DEPTH: both shall execute and o_count shall be unchanged.
REQ-024 o_count, o_empty and o_full shall be registered and consistent with each other on every cycle (o_empty = (o_count==0), o_full = (o_count==DEPTH)).
REQ-025 o_rd_data shall be a combinational read of the array at the read pointer; its value while o_empty=1 is don't-care.

Reset
REQ-026 On i_reset=0, the block shall asynchronously clear both pointers, o_count and o_overflow, and set o_empty=1 and o_full=0.
REQ-027 Array contents need not be cleared on reset.
REQ-028 A reset asserted mid-burst shall discard all stored bytes; the first write after release shall appear at o_rd_data.
REQ-029 Release of i_reset shall be synchronous to i_clk; a strobe on the first edge after release shall be honoured.

Configuration
REQ-030 With macro UART_RX_FIFO_OVF_FLAG_EN defined, o_overflow shall set on any write dropped per REQ-019 and hold until i_ovf_clr=1 or reset. If a drop and i_ovf_clr coincide on the same edge, the set wins.
REQ-031 With UART_RX_FIFO_OVF_FLAG_EN undefined, o_overflow shall be constant 0 and i_ovf_clr shall be ignored; all port widths shall be identical in both builds.

Verification
REQ-032 Reset, then write 0xA5, 0x3C on consecutive cycles -> o_rd_data=0xA5 and o_count=2; after one i_rd, o_rd_data=0x3C.
REQ-033 Write 16 bytes 0x00..0x0F -> o_full=1, o_count=16; a 17th write of 0xFF is dropped -> reads return 0x00..0x0F in order and o_overflow=1 (macro defined) or 0 (undefined).
REQ-034 Hold the FIFO at count 8 and run 40 cycles of simultaneous write+read with incrementing data -> o_count stays 8, pointers wrap, and output order is preserved.
REQ-035 With the FIFO empty, assert i_wr=1 (0x5A) and i_rd=1 together -> o_count=1 and o_rd_data=0x5A.
REQ-036 With the FIFO full, assert write+read together (0x77) -> o_count=16, o_overflow unchanged, and 0x77 is the last byte read out.
REQ-037 With 5 bytes queued, pulse i_reset low between edges -> o_empty=1 and o_count=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// UART receive byte FIFO: first-word-fall-through, registered count/flags.
// Optional sticky overflow flag enabled by defining UART_RX_FIFO_OVF_FLAG_EN.
module uart_rx_fifo #(
  parameter int NB_DATA = 8,
  parameter int NB_ADDR = 4
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_wr,
  input  logic [NB_DATA-1:0] i_wr_data,
  input  logic               i_rd,
  input  logic               i_ovf_clr,
  output logic [NB_DATA-1:0] o_rd_data,
  output logic               o_empty,
  output logic               o_full,
  output logic [NB_ADDR:0]   o_count,
  output logic               o_overflow
);

  localparam int DEPTH = 1 << NB_ADDR;
  localparam logic [NB_ADDR:0] CNT_FULL = (NB_ADDR+1)'(DEPTH);

  logic [NB_DATA-1:0] mem [DEPTH];
  logic [NB_ADDR-1:0] wr_ptr;
  logic [NB_ADDR-1:0] rd_ptr;
  logic [NB_ADDR:0]   count;
  logic [NB_ADDR:0]   count_nxt;
  logic               wr_ok;
  logic               rd_ok;
  logic               drop;

  // A full FIFO still accepts a write when a pop frees the head slot
  assign rd_ok = i_rd & ~o_empty;
  assign wr_ok = i_wr & (~o_full | rd_ok);
  assign drop  = i_wr & o_full & ~i_rd;

  always_comb begin
    count_nxt = count;
    unique case (1'b1)
      wr_ok & ~rd_ok: count_nxt = count + 1'b1;
      rd_ok & ~wr_ok: count_nxt = count - 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      o_empty <= 1'b1;
      o_full  <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      count   <= count_nxt;
      o_empty <= (count_nxt == '0);
      o_full  <= (count_nxt == CNT_FULL);
    end
  end

  always_ff @(posedge i_clk) begin
    if (wr_ok) mem[wr_ptr] <= i_wr_data;
  end

  assign o_rd_data = mem[rd_ptr];
  assign o_count   = count;

`ifdef UART_RX_FIFO_OVF_FLAG_EN
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      o_overflow <= 1'b0;
    end else if (drop) begin
      o_overflow <= 1'b1;
    end else if (i_ovf_clr) begin
      o_overflow <= 1'b0;
    end
  end
`else
  logic unused_ovf;
  assign unused_ovf = i_ovf_clr | drop;
  assign o_overflow = 1'b0;
`endif

endmodule
